// File: rtl/amm_master_pkg.sv
// Shared types and constants for the Avalon-MM block-transfer master.
// Ports: none (package only).
// Provides the engine state encoding and the per-word address stride.
package amm_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_REQ,
    READ_WAIT,
    DONE
  } state_t;

  // Byte distance between consecutive bus words.
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/amm_block_master.sv
// Avalon-MM master that runs sequential single-word block transfers: pattern
// fill (seed, seed+1, ...) in write mode, read-back with checksum in read mode.
// Ports: cmd_* (command from control logic, sampled in IDLE), status_* (busy,
// one-cycle done pulse, running sum and word count), master_* (Avalon-MM
// master bus). First request one cycle after start; writes stream one word
// per cycle; reads keep exactly one transaction outstanding. Bus outputs are
// registered and hold stable while master_waitrequest is high.
module amm_block_master
  import amm_master_pkg::*;
#(
  parameter int ADDRESSWIDTH = 26,
  parameter int DATAWIDTH    = 32,
  parameter int LENWIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_start,
  input  logic                    cmd_write,
  input  logic [ADDRESSWIDTH-1:0] cmd_address,
  input  logic [LENWIDTH-1:0]     cmd_length,
  input  logic [DATAWIDTH-1:0]    cmd_seed,
  output logic                    status_busy,
  output logic                    status_done,
  output logic [DATAWIDTH-1:0]    status_sum,
  output logic [LENWIDTH-1:0]     status_count,
  output logic [ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]    master_writedata,
  output logic                    master_write,
  output logic                    master_read,
  input  logic [DATAWIDTH-1:0]    master_readdata,
  input  logic                    master_readdatavalid,
  input  logic                    master_waitrequest
);

  state_t                  state_q;
  logic [ADDRESSWIDTH-1:0] addr_q;
  logic [LENWIDTH-1:0]     len_q;
  logic [LENWIDTH-1:0]     count_q;
  logic [DATAWIDTH-1:0]    sum_q;
  // Tracks seed + count, so the write data needs no adder on the output path.
  logic [DATAWIDTH-1:0]    wdata_q;
  logic                    write_q;
  logic                    read_q;
  logic                    busy_q;
  logic                    done_q;

  logic [ADDRESSWIDTH-1:0] addr_d;
  logic [LENWIDTH-1:0]     count_d;
  logic [ADDRESSWIDTH-1:0] start_addr_d;

  // Byte-lane bits of the start address are forced to zero.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cmd_address[1:0];

  always_comb begin
    addr_d       = addr_q + ADDRESSWIDTH'(WORD_BYTES);  // wraps modulo 2^ADDRESSWIDTH
    count_d      = count_q + LENWIDTH'(1);
    start_addr_d = {cmd_address[ADDRESSWIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_start) begin
            addr_q  <= start_addr_d;
            len_q   <= cmd_length;
            wdata_q <= cmd_seed;
            sum_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            if (cmd_length == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (cmd_write) begin
              state_q <= WRITE;
              write_q <= 1'b1;
            end else begin
              state_q <= READ_REQ;
              read_q  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (!master_waitrequest) begin
            count_q <= count_d;
            sum_q   <= sum_q + wdata_q;
            addr_q  <= addr_d;
            wdata_q <= wdata_q + DATAWIDTH'(1);
            if (count_d == len_q) begin
              state_q <= DONE;
              write_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        READ_REQ: begin
          if (!master_waitrequest) begin
            addr_q  <= addr_d;
            read_q  <= 1'b0;
            state_q <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          // Valid is only honoured here, which keeps one read outstanding and
          // discards stray responses in every other state.
          if (master_readdatavalid) begin
            sum_q   <= sum_q + master_readdata;
            count_q <= count_d;
            if (count_d == len_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ_REQ;
              read_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          write_q <= 1'b0;
          read_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign status_busy      = busy_q;
  assign status_done      = done_q;
  assign status_sum       = sum_q;
  assign status_count     = count_q;
  assign master_address   = addr_q;
  assign master_writedata = wdata_q;
  assign master_write     = write_q;
  assign master_read      = read_q;

endmodule

// File: tb/tb_amm_block_master.sv
module tb_amm_block_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_start;
  logic        cmd_write;
  logic [25:0] cmd_address;
  logic [15:0] cmd_length;
  logic [31:0] cmd_seed;
  logic        status_busy;
  logic        status_done;
  logic [31:0] status_sum;
  logic [15:0] status_count;
  logic [25:0] master_address;
  logic [31:0] master_writedata;
  logic        master_write;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_waitrequest;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  amm_block_master dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_address(cmd_address),
    .cmd_length(cmd_length), .cmd_seed(cmd_seed),
    .status_busy(status_busy), .status_done(status_done),
    .status_sum(status_sum), .status_count(status_count),
    .master_address(master_address), .master_writedata(master_writedata),
    .master_write(master_write), .master_read(master_read),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest)
  );

  // Slave read model (latency 2) plus bus monitor.
  logic        slv_rdv = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        stray_rdv;
  logic [31:0] stray_data;
  int          lat_cnt = 0;
  int          rd_idx = 0;
  int          wr_acc = 0;
  int          rd_acc = 0;
  int          ost = 0;
  logic        overlap = 1'b0;
  logic        any_req = 1'b0;
  logic [25:0] rd_addr [0:7];

  assign master_readdatavalid = slv_rdv | stray_rdv;
  assign master_readdata      = slv_rdv ? slv_rdata : stray_data;

  function automatic logic [31:0] slave_word(input int idx);
    case (idx)
      0:       slave_word = 32'h0000_0001;
      1:       slave_word = 32'h0000_0002;
      2:       slave_word = 32'hFFFF_FFFF;
      default: slave_word = 32'hDEAD_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    slv_rdv <= 1'b0;
    if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        slv_rdv   <= 1'b1;
        slv_rdata <= slave_word(rd_idx);
        rd_idx    <= rd_idx + 1;
      end
    end
    if (master_read && !master_waitrequest) begin
      lat_cnt <= 2;
      rd_addr[rd_acc[2:0]] <= master_address;
      rd_acc  <= rd_acc + 1;
      if (ost != 0) overlap <= 1'b1;
      ost <= ost + 1;
    end else if (slv_rdv) begin
      ost <= ost - 1;
    end
    if (master_write && !master_waitrequest) wr_acc <= wr_acc + 1;
    if (master_read || master_write) any_req <= 1'b1;
    if (cmd_start && !status_busy && reset_n) begin
      rd_idx  <= 0;
      wr_acc  <= 0;
      rd_acc  <= 0;
      ost     <= 0;
      overlap <= 1'b0;
      any_req <= 1'b0;
    end
  end

  // Presents a one-cycle start; returns in the first cycle after the sampling edge.
  task automatic do_start(input logic wr, input logic [25:0] addr,
                          input logic [15:0] len, input logic [31:0] seed);
    cmd_write   = wr;
    cmd_address = addr;
    cmd_length  = len;
    cmd_seed    = seed;
    cmd_start   = 1'b1;
    @(negedge clk);
    cmd_start   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({status_busy, status_done, master_write, master_read} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: busy/done/wr/rd=%b required 0000",
               {status_busy, status_done, master_write, master_read});
    end
    n_cmp++;
    if (status_sum !== 32'h0 || status_count !== 16'h0 || master_address !== 26'h0) begin
      n_err++;
      $display("FAIL reset_regs: sum=%h count=%h addr=%h required all 0",
               status_sum, status_count, master_address);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [25:0] ea;
    logic [31:0] ed;
    do_start(1'b1, 26'h100, 16'd4, 32'h10);
    for (int i = 0; i < 4; i++) begin
      ea = 26'h100 + 26'(4 * i);
      ed = 32'h10 + 32'(i);
      n_cmp++;
      if (master_write !== 1'b1 || status_busy !== 1'b1 ||
          master_address !== ea || master_writedata !== ed) begin
        n_err++;
        $display("FAIL write_word%0d: wr=%b busy=%b addr=%h data=%h required wr=1 busy=1 addr=%h data=%h",
                 i, master_write, status_busy, master_address, master_writedata, ea, ed);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (status_done !== 1'b1 || status_busy !== 1'b1 || master_write !== 1'b0 ||
        status_sum !== 32'h46 || status_count !== 16'd4) begin
      n_err++;
      $display("FAIL write_done: done=%b busy=%b wr=%b sum=%h count=%0d required 1 1 0 00000046 4",
               status_done, status_busy, master_write, status_sum, status_count);
    end
    @(negedge clk);
    n_cmp++;
    if (status_done !== 1'b0 || status_busy !== 1'b0 || status_sum !== 32'h46 ||
        status_count !== 16'd4 || wr_acc !== 4) begin
      n_err++;
      $display("FAIL write_idle: done=%b busy=%b sum=%h count=%0d accepts=%0d required 0 0 00000046 4 4",
               status_done, status_busy, status_sum, status_count, wr_acc);
    end
  endtask

  task automatic test_waitrequest();
    int k;
    do_start(1'b1, 26'h100, 16'd4, 32'h10);
    @(negedge clk);
    master_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) master_waitrequest = 1'b0;
      n_cmp++;
      if (master_write !== 1'b1 || master_address !== 26'h104 || master_writedata !== 32'h11) begin
        n_err++;
        $display("FAIL wait_hold%0d: wr=%b addr=%h data=%h required 1 104 00000011",
                 i, master_write, master_address, master_writedata);
      end
      if (i < 3) @(negedge clk);
    end
    k = 0;
    while (!status_done && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (status_done !== 1'b1 || status_sum !== 32'h46 || status_count !== 16'd4 || wr_acc !== 4) begin
      n_err++;
      $display("FAIL wait_final: done=%b sum=%h count=%0d accepts=%0d required 1 00000046 4 4",
               status_done, status_sum, status_count, wr_acc);
    end
    @(negedge clk);
  endtask

  task automatic test_read();
    int k;
    do_start(1'b0, 26'h200, 16'd3, 32'h0);
    n_cmp++;
    if (master_read !== 1'b1 || master_write !== 1'b0 || master_address !== 26'h200) begin
      n_err++;
      $display("FAIL read_first: rd=%b wr=%b addr=%h required 1 0 200",
               master_read, master_write, master_address);
    end
    k = 0;
    while (!status_done && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (status_done !== 1'b1 || status_sum !== 32'h2 || status_count !== 16'd3) begin
      n_err++;
      $display("FAIL read_final: done=%b sum=%h count=%0d required 1 00000002 3",
               status_done, status_sum, status_count);
    end
    n_cmp++;
    if (rd_acc !== 3 || overlap !== 1'b0 || rd_addr[0] !== 26'h200 ||
        rd_addr[1] !== 26'h204 || rd_addr[2] !== 26'h208) begin
      n_err++;
      $display("FAIL read_bus: reads=%0d overlap=%b addrs=%h %h %h required 3 0 200 204 208",
               rd_acc, overlap, rd_addr[0], rd_addr[1], rd_addr[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_len0();
    do_start(1'b1, 26'h80, 16'd0, 32'h77);
    n_cmp++;
    if (status_done !== 1'b1 || status_busy !== 1'b1 || status_count !== 16'd0 ||
        status_sum !== 32'h0 || master_write !== 1'b0) begin
      n_err++;
      $display("FAIL len0_done: done=%b busy=%b count=%0d sum=%h wr=%b required 1 1 0 0 0",
               status_done, status_busy, status_count, status_sum, master_write);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (status_done !== 1'b0 || status_busy !== 1'b0 || any_req !== 1'b0) begin
      n_err++;
      $display("FAIL len0_after: done=%b busy=%b bus_req_seen=%b required 0 0 0",
               status_done, status_busy, any_req);
    end
  endtask

  task automatic test_wrap();
    do_start(1'b1, 26'h3FFFFFC, 16'd2, 32'h5);
    n_cmp++;
    if (master_address !== 26'h3FFFFFC || master_writedata !== 32'h5) begin
      n_err++;
      $display("FAIL wrap_first: addr=%h data=%h required 3fffffc 00000005",
               master_address, master_writedata);
    end
    @(negedge clk);
    n_cmp++;
    if (master_write !== 1'b1 || master_address !== 26'h0 || master_writedata !== 32'h6) begin
      n_err++;
      $display("FAIL wrap_second: wr=%b addr=%h data=%h required 1 0000000 00000006",
               master_write, master_address, master_writedata);
    end
    @(negedge clk);
    n_cmp++;
    if (status_done !== 1'b1 || status_sum !== 32'hB || status_count !== 16'd2) begin
      n_err++;
      $display("FAIL wrap_done: done=%b sum=%h count=%0d required 1 0000000b 2",
               status_done, status_sum, status_count);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_start_and_reset();
    int k;
    do_start(1'b0, 26'h300, 16'd3, 32'h0);
    @(negedge clk);
    do_start(1'b1, 26'h40, 16'd1, 32'hAA);
    n_cmp++;
    if (master_write !== 1'b0 || status_busy !== 1'b1 || status_count !== 16'd0) begin
      n_err++;
      $display("FAIL busy_start: wr=%b busy=%b count=%0d required 0 1 0",
               master_write, status_busy, status_count);
    end
    k = 0;
    while (status_count == 16'd0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (status_count !== 16'd1 || status_sum !== 32'h1 || master_write !== 1'b0) begin
      n_err++;
      $display("FAIL busy_first_word: count=%0d sum=%h wr=%b required 1 00000001 0",
               status_count, status_sum, master_write);
    end
    k = 0;
    while (!master_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_cmp++;
    if (master_read !== 1'b0 || master_address !== 26'h308 || status_busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_second_read: rd=%b addr=%h busy=%b required 0 308 1",
               master_read, master_address, status_busy);
    end
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({status_busy, status_done, master_write, master_read} !== 4'b0000 ||
        status_sum !== 32'h0 || status_count !== 16'h0 || master_address !== 26'h0) begin
      n_err++;
      $display("FAIL midreset: busy/done/wr/rd=%b sum=%h count=%h addr=%h required 0000 0 0 0",
               {status_busy, status_done, master_write, master_read},
               status_sum, status_count, master_address);
    end
    reset_n    = 1'b1;
    stray_data = 32'h55;
    stray_rdv  = 1'b1;
    repeat (2) @(negedge clk);
    stray_rdv  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (status_sum !== 32'h0 || status_count !== 16'h0 || status_done !== 1'b0 ||
          status_busy !== 1'b0) begin
        n_err++;
        $display("FAIL stray_rdv%0d: sum=%h count=%0d done=%b busy=%b required 0 0 0 0",
                 i, status_sum, status_count, status_done, status_busy);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n            = 1'b0;
    cmd_start          = 1'b0;
    cmd_write          = 1'b0;
    cmd_address        = '0;
    cmd_length         = '0;
    cmd_seed           = '0;
    master_waitrequest = 1'b0;
    stray_rdv          = 1'b0;
    stray_data         = '0;
    @(negedge clk);
    test_reset();
    test_write();
    test_waitrequest();
    test_read();
    test_len0();
    test_wrap();
    test_busy_start_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
